riscv32ima_fetch: RTL and testbench

Instruction fetch stage of the riscv32ima core: the producer end of the `fetch_*` valid/ready channel consumed by the decode stage. It owns the fetch PC, issues in-order word reads to instruction memory, buffers returned instructions in a small FIFO and presents them with their addresses. It applies PC redirects from the writeback stage (`wback_pc_wen`/`wback_pc`), flushing buffered and in-flight instructions.

---
 rtl/riscv32ima_pkg.sv | 28 ++
 rtl/riscv32ima_fetch_fifo.sv | 51 +++++
 rtl/riscv32ima_fetch.sv | 100 ++++++++++
 tb/tb_riscv32ima_fetch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv32ima_pkg.sv
// Shared definitions for the riscv32ima core: base opcodes, instruction size
// and the default fetch start address.
package riscv32ima_pkg;

  localparam int          INST_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [6:0] {
    LOAD     = 7'b000_0011,
    MISC_MEM = 7'b000_1111,
    OP_IMM   = 7'b001_0011,
    AUIPC    = 7'b001_0111,
    STORE    = 7'b010_0011,
    AMO      = 7'b010_1111,
    OP       = 7'b011_0011,
    LUI      = 7'b011_0111,
    BRANCH   = 7'b110_0011,
    JALR     = 7'b110_0111,
    JAL      = 7'b110_1111,
    SYSTEM   = 7'b111_0011
  } opcode_t;

  // Clear the two byte-offset bits of a 32-bit address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv32ima_fetch_fifo.sv
// Small synchronous FIFO holding {address, instruction} pairs for the fetch
// stage. Head entry is visible combinationally from the storage registers;
// flush empties the buffer in one cycle.
module riscv32ima_fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; flush overrides any push or pop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1'b1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1'b1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/riscv32ima_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads to
// instruction memory under a credit limit equal to the buffer depth, buffers
// returned words and presents them to decode. A writeback redirect flushes
// the buffer and marks every still-outstanding response as stale.
module riscv32ima_fetch
  import riscv32ima_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [ADDR_WIDTH-1:0] fetch_address,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  wback_pc_wen,
  input  logic [ADDR_WIDTH-1:0] wback_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;  // holds 0..FIFO_DEPTH
  localparam int FW = CW + 1;                  // holds in_flight + count
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_BYTES);

  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [CW-1:0]         in_flight;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         count;
  logic [FW-1:0]         credit_used;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  pop;
  logic                  push;
  logic                  req_fire;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] head;

  assign redirect_pc = {wback_pc[ADDR_WIDTH-1:2], 2'b00};
  assign fetch_valid = (count != '0);
  assign pop         = fetch_valid && fetch_ready;
  // Slots already promised: outstanding reads plus buffered words, minus the
  // one leaving this cycle. A new request is allowed only if it still fits.
  assign credit_used    = FW'(in_flight) + FW'(count) - FW'(pop);
  assign imem_req_valid = nrst && !wback_pc_wen && (credit_used < FW'(FIFO_DEPTH));
  assign imem_req_addr  = req_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop_cnt == '0) && !wback_pc_wen;

  assign fetch_address = head[ADDR_WIDTH+INST_WIDTH-1:INST_WIDTH];
  assign fetch_data    = {{(DATA_WIDTH-INST_WIDTH){1'b0}}, head[INST_WIDTH-1:0]};

  // PC registers plus outstanding/stale response bookkeeping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      req_pc    <= RESET_PC;
      rsp_pc    <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
    end else begin
      in_flight <= in_flight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (wback_pc_wen) begin
        req_pc   <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= in_flight - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          req_pc <= req_pc + PC_STEP;
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1'b1);
        end
        if (push) begin
          rsp_pc <= rsp_pc + PC_STEP;
        end
      end
    end
  end

  riscv32ima_fetch_fifo #(
    .WIDTH (ADDR_WIDTH + INST_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (pop),
    .flush     (wback_pc_wen),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_riscv32ima_fetch.sv
// Self-checking bench for riscv32ima_fetch: an in-order instruction memory
// with configurable latency, and a program-order model of the addresses the
// decode stage and the memory should see.
module tb_riscv32ima_fetch;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_address;
  logic [63:0] fetch_data;
  logic        wback_pc_wen = 1'b0;
  logic [31:0] wback_pc = 32'h0;

  always #5 clk = ~clk;

  riscv32ima_fetch dut (
    .clk            (clk),
    .nrst           (nrst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_address  (fetch_address),
    .fetch_data     (fetch_data),
    .wback_pc_wen   (wback_pc_wen),
    .wback_pc       (wback_pc)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat      = 1;
  int          cyc      = 0;
  int          n_req    = 0;
  int          n_hs     = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] exp_req_pc;
  logic [31:0] exp_fetch_pc;
  logic        s_fv, s_rv, s_hs, s_rsp;
  logic [31:0] s_ra, s_fa;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_F00F) + 32'h0001_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs at negedge, score what the next posedge will do.
  task automatic step(input logic fr, input logic rr, input logic redir, input logic [31:0] tgt);
    @(negedge clk);
    fetch_ready    = fr;
    imem_req_ready = rr;
    wback_pc_wen   = redir;
    wback_pc       = tgt;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    #1;
    s_fv  = fetch_valid;
    s_rv  = imem_req_valid;
    s_ra  = imem_req_addr;
    s_fa  = fetch_address;
    s_hs  = fetch_valid && fetch_ready;
    s_rsp = imem_rsp_valid;
    if (redir) check("redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", {32'h0, imem_req_addr}, {32'h0, exp_req_pc});
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
      exp_req_pc = exp_req_pc + 32'd4;
      n_req++;
    end
    if (fetch_valid && fetch_ready) begin
      check("fetch_address", {32'h0, fetch_address}, {32'h0, exp_fetch_pc});
      check("fetch_data", fetch_data, {32'h0, inst_of(exp_fetch_pc)});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      n_hs++;
    end
    if (redir) begin
      exp_req_pc   = {tgt[31:2], 2'b00};
      exp_fetch_pc = {tgt[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst           = 1'b0;
    fetch_ready    = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    wback_pc_wen   = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    #1;
    check("rst_fetch_valid", {63'h0, fetch_valid}, 64'h0);
    check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    check("rst_fetch_address", {32'h0, fetch_address}, 64'h0);
    check("rst_fetch_data", fetch_data, 64'h0);
    @(posedge clk);
    #2 nrst = 1'b1;
    cyc          = 0;
    n_req        = 0;
    n_hs         = 0;
    exp_req_pc   = 32'h0;
    exp_fetch_pc = 32'h0;
  endtask

  initial begin
    // Back-to-back streaming, latency 1.
    lat = 1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) check("first_req", {32'h0, s_ra}, 64'h0);
      if (i >= 2) check("stream_fetch_valid", {63'h0, s_fv}, 64'h1);
    end
    check("stream_hs_count", 64'(n_hs), 64'd10);

    // Decode stalled: credit limit caps requests, head holds.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_fv) check("stall_head", {32'h0, s_fa}, 64'h0);
    end
    check("stall_req_count", 64'(n_req), 64'd4);
    check("stall_req_valid", {63'h0, s_rv}, 64'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("stall_release_hs", 64'(n_hs >= 5), 64'h1);

    // Redirect with two reads outstanding at latency 3.
    lat = 3;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_inflight", 64'(mq_addr.size()), 64'd2);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    check("redir_next_valid", {63'h0, s_fv}, 64'h0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_hs_after", 64'(n_hs >= 3), 64'h1);

    // Redirect coinciding with a response and a decode handshake.
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    check("coinc_hs", {63'h0, s_hs}, 64'h1);
    check("coinc_rsp", {63'h0, s_rsp}, 64'h1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("coinc_next_fv", {63'h0, s_fv}, 64'h0);
    check("coinc_next_rv", {63'h0, s_rv}, 64'h1);
    check("coinc_next_ra", {32'h0, s_ra}, 64'h0000_0200);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    n_hs = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_hs", 64'(n_hs >= 4), 64'h1);
    check("wrap_req_pc", {32'h0, exp_req_pc} < 64'h20 ? 64'h1 : 64'h0, 64'h1);

    // Reset asserted mid-stream with reads outstanding.
    lat = 2;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    #2 nrst = 1'b0;
    #1;
    check("midrst_fetch_valid", {63'h0, fetch_valid}, 64'h0);
    check("midrst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("midrst_first_req", 64'(n_req), 64'd1);
    check("midrst_first_addr", {32'h0, s_ra}, 64'h0);

    // Randomized traffic: backpressure on both sides and sporadic redirects.
    for (int r = 0; r < 3; r++) begin
      lat = 1 + r + int'($urandom_range(0, 1));
      do_reset();
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 31) == 0, $urandom());
      end
      check("rand_progress", 64'(n_hs > 20), 64'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
